// File: rtl/game_sequencer.sv
// Game-flow controller for the snake top level: frame-rate divider, direction queue,
// speed levels, lives and the IDLE/PLAY/PAUSE/DYING/GAME_OVER sequence.
module game_sequencer #(
  parameter int TICKS_BASE     = 5_000_000,
  parameter int TICKS_STEP     = 500_000,
  parameter int TICKS_MIN      = 1_000_000,
  parameter int TICK_W         = 25,
  parameter int FOOD_PER_LEVEL = 5,
  parameter int MAX_LEVEL      = 7,
  parameter int LIVES          = 3,
  parameter int DEATH_FRAMES   = 10,
  parameter int DIR_Q_DEPTH    = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       pause,
  input  logic [1:0] dir_in,
  input  logic       dir_valid,
  input  logic       food_eaten,
  input  logic       collision,
  output logic       frame_tick,
  output logic       update_snake,
  output logic       respawn,
  output logic       score_inc,
  output logic       game_over,
  output logic [1:0] direction_out,
  output logic [3:0] level,
  output logic [2:0] lives_left,
  output logic [2:0] state
);

  localparam int QW = (DIR_Q_DEPTH > 1) ? $clog2(DIR_Q_DEPTH) : 1;
  localparam int FW = $clog2(FOOD_PER_LEVEL + 1);
  localparam int DW = $clog2(DEATH_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_DYING = 3'd3,
    S_OVER  = 3'd4
  } st_t;

  st_t cur, nxt;

  logic [TICK_W-1:0] cnt, period, period_calc;
  logic [FW-1:0]     food_cnt;
  logic [DW-1:0]     death_cnt;
  logic              food_prev, col_prev;
  logic [1:0]        dq [DIR_Q_DEPTH];
  logic [QW-1:0]     head, tail_idx, wr_idx;
  logic [QW:0]       occ;
  logic [1:0]        ref_dir;
  logic [31:0]       dec32, per32;

  logic wrap, running, tick_now, food_rise, col_rise, restart, revive, push, pop;
  logic tick_nxt, upd_nxt, resp_nxt, score_nxt, over_nxt;

  assign wrap      = (cnt == period - 1'b1);
  assign running   = (cur == S_PLAY) || (cur == S_DYING);
  assign tick_now  = running && wrap;
  assign food_rise = food_eaten && !food_prev;
  assign col_rise  = collision && !col_prev;
  assign restart   = start && ((cur == S_IDLE) || (cur == S_OVER));
  assign revive    = (cur == S_DYING) && tick_now && (death_cnt == DW'(DEATH_FRAMES - 1));

  // New strobes are checked against the last queued move, not the one on screen.
  assign tail_idx = head + occ[QW-1:0] - 1'b1;
  assign wr_idx   = head + occ[QW-1:0];
  assign ref_dir  = (occ == '0) ? direction_out : dq[tail_idx];
  assign push     = (cur == S_PLAY) && dir_valid && (occ != (QW+1)'(DIR_Q_DEPTH)) &&
                    (dir_in != ref_dir) && (dir_in != (ref_dir ^ 2'b10));
  assign pop      = (cur == S_PLAY) && wrap && (occ != '0);

  always_comb begin
    dec32 = 32'(level) * 32'(TICKS_STEP);
    if (dec32 + 32'(TICKS_MIN) > 32'(TICKS_BASE)) per32 = 32'(TICKS_MIN);
    else                                         per32 = 32'(TICKS_BASE) - dec32;
    period_calc = TICK_W'(per32);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cur <= S_IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:  if (start) nxt = S_PLAY;
      S_PLAY:  if (col_rise)   nxt = (lives_left == 3'd1) ? S_OVER : S_DYING;
               else if (pause) nxt = S_PAUSE;
      S_PAUSE: if (pause) nxt = S_PLAY;
      S_DYING: if (revive) nxt = S_PLAY;
      S_OVER:  if (start) nxt = S_PLAY;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tick_nxt  = tick_now;
    upd_nxt   = tick_now && (cur == S_PLAY);
    resp_nxt  = restart || revive;
    score_nxt = (cur == S_PLAY) && food_rise && !col_rise;
    over_nxt  = (nxt == S_OVER);
  end

  assign state = cur;

  always_ff @(posedge clk) begin
    if (push) dq[wr_idx] <= dir_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_tick    <= 1'b0;
      update_snake  <= 1'b0;
      respawn       <= 1'b0;
      score_inc     <= 1'b0;
      game_over     <= 1'b0;
      food_prev     <= 1'b0;
      col_prev      <= 1'b0;
      cnt           <= '0;
      period        <= TICK_W'(TICKS_BASE);
      head          <= '0;
      occ           <= '0;
      direction_out <= 2'b01;
      lives_left    <= 3'(LIVES);
      level         <= '0;
      food_cnt      <= '0;
      death_cnt     <= '0;
    end else begin
      frame_tick   <= tick_nxt;
      update_snake <= upd_nxt;
      respawn      <= resp_nxt;
      score_inc    <= score_nxt;
      game_over    <= over_nxt;
      food_prev    <= food_eaten;
      col_prev     <= collision;

      if (resp_nxt)     cnt <= '0;
      else if (running) cnt <= wrap ? '0 : cnt + 1'b1;

      if (restart)       period <= TICK_W'(TICKS_BASE);
      else if (tick_now) period <= period_calc;

      if (resp_nxt) begin
        head          <= '0;
        occ           <= '0;
        direction_out <= 2'b01;
      end else begin
        if (pop) begin
          direction_out <= dq[head];
          head          <= head + 1'b1;
        end
        case ({push, pop})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: ;
        endcase
      end

      if (restart) begin
        lives_left <= 3'(LIVES);
        level      <= '0;
        food_cnt   <= '0;
      end else begin
        if ((cur == S_PLAY) && col_rise) lives_left <= lives_left - 1'b1;
        if (score_nxt) begin
          if (food_cnt == FW'(FOOD_PER_LEVEL - 1)) begin
            food_cnt <= '0;
            if (level != 4'(MAX_LEVEL)) level <= level + 1'b1;
          end else begin
            food_cnt <= food_cnt + 1'b1;
          end
        end
      end

      if ((cur == S_PLAY) && col_rise)       death_cnt <= '0;
      else if ((cur == S_DYING) && tick_now) death_cnt <= death_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: scenario tasks with inline checks against a queue-based
// direction model and arithmetic expectations for frame spacing, levels and lives.
module tb_game_sequencer;
  localparam int TB = 10, TS = 2, TM = 4, FPL = 2, LV = 2, DF = 3, ML = 7;

  logic       clk = 1'b0, rstn = 1'b0, start = 1'b0, pause = 1'b0;
  logic       dir_valid = 1'b0, food_eaten = 1'b0, collision = 1'b0;
  logic [1:0] dir_in = 2'b00;
  logic       frame_tick, update_snake, respawn, score_inc, game_over;
  logic [1:0] direction_out;
  logic [3:0] level;
  logic [2:0] lives_left, state;

  int checks = 0, errors = 0;
  logic [1:0] q_m[$];
  logic [1:0] dir_m = 2'b01;

  always #5 clk = ~clk;

  game_sequencer #(
    .TICKS_BASE(TB), .TICKS_STEP(TS), .TICKS_MIN(TM), .TICK_W(25),
    .FOOD_PER_LEVEL(FPL), .MAX_LEVEL(ML), .LIVES(LV), .DEATH_FRAMES(DF), .DIR_Q_DEPTH(2)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .pause(pause), .dir_in(dir_in),
    .dir_valid(dir_valid), .food_eaten(food_eaten), .collision(collision),
    .frame_tick(frame_tick), .update_snake(update_snake), .respawn(respawn),
    .score_inc(score_inc), .game_over(game_over), .direction_out(direction_out),
    .level(level), .lives_left(lives_left), .state(state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_period(input int lvl);
    int p;
    p = TB - lvl * TS;
    if (p < TM) p = TM;
    return p;
  endfunction

  // Direction model: accept if not same / not reverse of the last queued move, depth 2.
  task automatic model_push(input logic [1:0] d);
    logic [1:0] r;
    r = (q_m.size() > 0) ? q_m[q_m.size() - 1] : dir_m;
    if (q_m.size() < 2 && d != r && d != (r ^ 2'b10)) q_m.push_back(d);
  endtask

  task automatic drive_dir(input logic v, input logic [1:0] d);
    int pre;
    pre = q_m.size();
    dir_valid = v; dir_in = d;
    cyc();
    dir_valid = 1'b0;
    if (v) model_push(d);
    if (update_snake && pre > 0) dir_m = q_m.pop_front();
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      n++;
      if (frame_tick) begin
        if (update_snake && q_m.size() > 0) dir_m = q_m.pop_front();
        return;
      end
    end
    checks++; errors++;
    $display("FAIL tick_timeout got no frame_tick want one within 200 cycles");
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) cyc();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (direction_out !== 2'b01) begin errors++; $display("FAIL reset_dir got %0d want 1", direction_out); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (lives_left !== 3'(LV)) begin errors++; $display("FAIL reset_lives got %0d want %0d", lives_left, LV); end
    checks++; if ({frame_tick, update_snake, respawn, score_inc, game_over} !== 5'b0)
      begin errors++; $display("FAIL reset_pulses got %b want 00000", {frame_tick, update_snake, respawn, score_inc, game_over}); end
    rstn = 1'b1;
    repeat (4) cyc();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_hold got %0d want 0", state); end
  endtask

  task automatic test_start();
    int r, t1, n;
    start = 1'b1; cyc(); start = 1'b0;
    q_m.delete(); dir_m = 2'b01;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL start_state got %0d want 1", state); end
    checks++; if (respawn !== 1'b1) begin errors++; $display("FAIL start_respawn got %0d want 1", respawn); end
    r = 0; t1 = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (respawn) r++;
      if (update_snake) begin t1 = i; break; end
    end
    checks++; if (t1 != TB) begin errors++; $display("FAIL first_tick got %0d want %0d", t1, TB); end
    checks++; if (r != 0) begin errors++; $display("FAIL respawn_once got %0d extra want 0", r); end
    wait_tick(n);
    checks++; if (n != TB || update_snake !== 1'b1)
      begin errors++; $display("FAIL tick_spacing got %0d upd %0d want %0d upd 1", n, update_snake, TB); end
    checks++; if (direction_out !== 2'b01) begin errors++; $display("FAIL start_dir got %0d want 1", direction_out); end
  endtask

  task automatic test_dir_queue();
    int n;
    drive_dir(1'b1, 2'b11);
    drive_dir(1'b1, 2'b00);
    drive_dir(1'b1, 2'b11);
    drive_dir(1'b1, 2'b10);
    wait_tick(n);
    checks++; if (n != TB - 4) begin errors++; $display("FAIL dq_tick1 got %0d want %0d", n, TB - 4); end
    checks++; if (direction_out !== 2'b00) begin errors++; $display("FAIL dq_pop1 got %0d want 0", direction_out); end
    wait_tick(n);
    checks++; if (direction_out !== 2'b11) begin errors++; $display("FAIL dq_pop2 got %0d want 3", direction_out); end
    wait_tick(n);
    checks++; if (direction_out !== 2'b11) begin errors++; $display("FAIL dq_drop got %0d want 3", direction_out); end
  endtask

  task automatic test_random_dir();
    int n;
    for (int i = 0; i < 120; i++) begin
      drive_dir($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
      checks++;
      if (direction_out !== dir_m) begin
        errors++; $display("FAIL rand_dir cycle %0d got %0d want %0d", i, direction_out, dir_m);
      end
    end
    wait_tick(n);
    wait_tick(n);
    checks++; if (direction_out !== dir_m) begin errors++; $display("FAIL rand_drain got %0d want %0d", direction_out, dir_m); end
  endtask

  task automatic test_pause();
    int n, m, bad;
    wait_tick(n);
    repeat (5) cyc();
    pause = 1'b1; cyc(); pause = 1'b0;
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL pause_state got %0d want 2", state); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      dir_valid = 1'b1; dir_in = direction_out + 2'd1;
      food_eaten = ~food_eaten;
      cyc();
      if (frame_tick || score_inc || state !== 3'd2) bad++;
    end
    dir_valid = 1'b0; food_eaten = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL pause_frozen got %0d active cycles want 0", bad); end
    pause = 1'b1; cyc(); pause = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL resume_state got %0d want 1", state); end
    wait_tick(m);
    n = 1 + m;
    checks++; if (n != 5) begin errors++; $display("FAIL resume_tick got %0d want 5", n); end
    checks++; if (direction_out !== dir_m) begin errors++; $display("FAIL pause_dir got %0d want %0d", direction_out, dir_m); end
  endtask

  task automatic test_food();
    int n, foods, exp_lvl, bad;
    foods = 0; bad = 0;
    for (int l = 1; l <= 5; l++) begin
      for (int k = 0; k < FPL; k++) begin
        food_eaten = 1'b1; cyc();
        if (score_inc !== 1'b1) bad++;
        repeat ($urandom_range(1, 3)) begin cyc(); if (score_inc !== 1'b0) bad++; end
        food_eaten = 1'b0;
        repeat ($urandom_range(1, 3)) cyc();
        foods++;
      end
      exp_lvl = foods / FPL;
      if (exp_lvl > ML) exp_lvl = ML;
      checks++; if (level !== 4'(exp_lvl)) begin errors++; $display("FAIL level got %0d want %0d", level, exp_lvl); end
      wait_tick(n);
      wait_tick(n);
      checks++; if (n != exp_period(exp_lvl))
        begin errors++; $display("FAIL level_spacing lvl %0d got %0d want %0d", exp_lvl, n, exp_period(exp_lvl)); end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL score_pulses got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_dying_and_over();
    int ticks, upd, n;
    logic seen;
    logic [3:0] lvl0;
    lvl0 = level;
    collision = 1'b1; cyc(); collision = 1'b0;
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL dying_state got %0d want 3", state); end
    checks++; if (lives_left !== 3'(LV - 1)) begin errors++; $display("FAIL dying_lives got %0d want %0d", lives_left, LV - 1); end
    ticks = 0; upd = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc();
      if (frame_tick) ticks++;
      if (update_snake) upd++;
      if (respawn) seen = 1'b1;
    end
    q_m.delete(); dir_m = 2'b01;
    checks++; if (!seen) begin errors++; $display("FAIL revive_timeout got no respawn want one"); end
    checks++; if (ticks != DF || upd != 0)
      begin errors++; $display("FAIL dying_ticks got %0d ticks %0d upd want %0d ticks 0 upd", ticks, upd, DF); end
    checks++; if (state !== 3'd1 || direction_out !== 2'b01 || level !== lvl0)
      begin errors++; $display("FAIL revive got st %0d dir %0d lvl %0d want 1 1 %0d", state, direction_out, level, lvl0); end
    wait_tick(n);
    checks++; if (n != exp_period(int'(lvl0))) begin errors++; $display("FAIL revive_tick got %0d want %0d", n, exp_period(int'(lvl0))); end
    collision = 1'b1; cyc(); collision = 1'b0;
    checks++; if (state !== 3'd4 || game_over !== 1'b1 || lives_left !== 3'd0)
      begin errors++; $display("FAIL game_over got st %0d go %0d lives %0d want 4 1 0", state, game_over, lives_left); end
    repeat (5) cyc();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL over_hold got %0d want 4", state); end
    start = 1'b1; cyc(); start = 1'b0;
    q_m.delete(); dir_m = 2'b01;
    checks++; if (state !== 3'd1 || lives_left !== 3'(LV) || level !== 4'd0 || respawn !== 1'b1 || game_over !== 1'b0)
      begin errors++; $display("FAIL restart got st %0d lives %0d lvl %0d rsp %0d go %0d want 1 %0d 0 1 0",
                               state, lives_left, level, respawn, game_over, LV); end
    wait_tick(n);
    checks++; if (n != TB) begin errors++; $display("FAIL restart_tick got %0d want %0d", n, TB); end
  endtask

  task automatic test_simul_and_reset();
    int bad;
    food_eaten = 1'b1; collision = 1'b1; cyc(); food_eaten = 1'b0; collision = 1'b0;
    checks++; if (score_inc !== 1'b0 || lives_left !== 3'(LV - 1) || state !== 3'd3)
      begin errors++; $display("FAIL simul got sc %0d lives %0d st %0d want 0 %0d 3", score_inc, lives_left, state, LV - 1); end
    bad = 0;
    repeat (3) begin cyc(); if (score_inc) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL simul_score got %0d want 0", bad); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || lives_left !== 3'(LV) || level !== 4'd0 || direction_out !== 2'b01 || game_over !== 1'b0 ||
                  {frame_tick, update_snake, respawn, score_inc} !== 4'b0)
      begin errors++; $display("FAIL async_reset got st %0d lives %0d lvl %0d dir %0d go %0d", state, lives_left, level, direction_out, game_over); end
    repeat (2) cyc();
    rstn = 1'b1;
    repeat (30) cyc();
    checks++; if (state !== 3'd0 || frame_tick !== 1'b0) begin errors++; $display("FAIL post_reset got st %0d want 0", state); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_dir_queue();
    test_random_dir();
    test_pause();
    test_food();
    test_dying_and_over();
    test_simul_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
